// File: rtl/line_buffer_rf.sv
// line_buffer_rf: circular ROWS x COLS pixel line buffer that streams each written column
// bit-serially (LSB first), with row order normalised so bit 0 is always the oldest row.
module line_buffer_rf #(
  parameter int ROWS = 3,
  parameter int COLS = 9,
  parameter int PIX_W = 8,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int BW = (PIX_W > 1) ? $clog2(PIX_W) : 1
) (
  input  logic             phi1,
  input  logic             reset_s1,
  input  logic             pix_valid_s1,
  output logic             pix_ready_s1,
  input  logic [PIX_W-1:0] pixel_s1,
  input  logic             bits_ready_s1,
  output logic             bits_valid_s1,
  output logic [ROWS-1:0]  bits_v1,
  output logic             bits_last_s1,
  output logic [COLS-1:0]  col_sel_s1,
  output logic [RW-1:0]    row_ptr_s1,
  output logic             line_done_s1
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [PIX_W-1:0] mem [ROWS][COLS];
  logic [PIX_W-1:0] shreg [ROWS];
  logic [PIX_W-1:0] load [ROWS];
  logic [CW-1:0] col;
  logic [BW-1:0] bit_idx;
  logic take, cons, last_cons;
  assign pix_ready_s1 = state == IDLE;
  assign bits_valid_s1 = state == SHIFT;
  assign bits_last_s1 = bits_valid_s1 && bit_idx == BW'(PIX_W - 1);
  assign take = pix_ready_s1 && pix_valid_s1;
  assign cons = bits_valid_s1 && bits_ready_s1;
  assign last_cons = cons && bits_last_s1;
  always_ff @(posedge phi1 or posedge reset_s1)
    if (reset_s1) state <= IDLE;
    else state <= state_n;
  always_comb state_n = take ? SHIFT : last_cons ? IDLE : state;
  // Oldest row first; the row being written takes the incoming pixel directly.
  always_comb
    for (int k = 0; k < ROWS; k++) begin
      load[k] = (k == ROWS - 1) ? pixel_s1 : mem[RW'((int'(row_ptr_s1) + 1 + k) % ROWS)][col];
      bits_v1[k] = bits_valid_s1 && shreg[k][0];
    end
  always_ff @(posedge phi1 or posedge reset_s1)
    if (reset_s1) begin
      for (int r = 0; r < ROWS; r++) begin
        shreg[r] <= '0;
        for (int c = 0; c < COLS; c++) mem[r][c] <= '0;
      end
      col <= '0;
      bit_idx <= '0;
      row_ptr_s1 <= '0;
      col_sel_s1 <= COLS'(1);
      line_done_s1 <= 1'b0;
    end else begin
      line_done_s1 <= last_cons && col == CW'(COLS - 1);
      if (take) begin
        mem[row_ptr_s1][col] <= pixel_s1;
        for (int k = 0; k < ROWS; k++) shreg[k] <= load[k];
        bit_idx <= '0;
      end
      if (cons) begin
        for (int k = 0; k < ROWS; k++) shreg[k] <= shreg[k] >> 1;
        bit_idx <= bit_idx + 1'b1;
      end
      if (last_cons) begin
        col <= (col == CW'(COLS - 1)) ? '0 : col + 1'b1;
        col_sel_s1 <= {col_sel_s1[COLS-2:0], col_sel_s1[COLS-1]};
        if (col == CW'(COLS - 1))
          row_ptr_s1 <= (row_ptr_s1 == RW'(ROWS - 1)) ? '0 : row_ptr_s1 + 1'b1;
      end
    end
endmodule

// File: tb/tb_line_buffer_rf.sv
// tb_line_buffer_rf: directed tests with a per-cycle reference model of the line buffer.
module tb_line_buffer_rf;
  localparam int ROWS = 3, COLS = 9, PIX_W = 8;
  logic phi1 = 0, reset_s1 = 1, pix_valid_s1 = 0, bits_ready_s1 = 1;
  logic [PIX_W-1:0] pixel_s1 = '0;
  logic pix_ready_s1, bits_valid_s1, bits_last_s1, line_done_s1;
  logic [ROWS-1:0] bits_v1;
  logic [COLS-1:0] col_sel_s1;
  logic [1:0] row_ptr_s1;
  int errors = 0, checks = 0;

  line_buffer_rf #(.ROWS(ROWS), .COLS(COLS), .PIX_W(PIX_W)) dut (
    .phi1(phi1), .reset_s1(reset_s1), .pix_valid_s1(pix_valid_s1), .pix_ready_s1(pix_ready_s1),
    .pixel_s1(pixel_s1), .bits_ready_s1(bits_ready_s1), .bits_valid_s1(bits_valid_s1),
    .bits_v1(bits_v1), .bits_last_s1(bits_last_s1), .col_sel_s1(col_sel_s1),
    .row_ptr_s1(row_ptr_s1), .line_done_s1(line_done_s1));

  always #5 phi1 = ~phi1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic to_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Reference model: memory image, pointers, and the captured column being read out.
  int m_mem[ROWS][COLS];
  int m_word[ROWS];
  int m_col, m_rp, m_nb;
  bit m_busy, m_ld;
  always @(posedge phi1 or posedge reset_s1) begin
    if (reset_s1) begin
      for (int r = 0; r < ROWS; r++) begin
        m_word[r] = 0;
        for (int c = 0; c < COLS; c++) m_mem[r][c] = 0;
      end
      m_col = 0; m_rp = 0; m_nb = 0; m_busy = 0; m_ld = 0;
    end else begin
      m_ld = 0;
      if (!m_busy && pix_valid_s1) begin
        m_mem[m_rp][m_col] = int'(pixel_s1);
        for (int k = 0; k < ROWS; k++) m_word[k] = m_mem[(m_rp + 1 + k) % ROWS][m_col];
        m_busy = 1;
        m_nb = 0;
      end else if (m_busy && bits_ready_s1) begin
        m_nb++;
        if (m_nb == PIX_W) begin
          m_busy = 0;
          if (m_col == COLS - 1) begin
            m_col = 0;
            m_rp = (m_rp + 1) % ROWS;
            m_ld = 1;
          end else m_col++;
        end
      end
    end
  end

  function automatic logic [ROWS-1:0] exp_bits();
    logic [ROWS-1:0] e;
    for (int k = 0; k < ROWS; k++) e[k] = m_busy && (((m_word[k] >> m_nb) & 1) == 1);
    return e;
  endfunction

  always @(negedge phi1) begin
    chk("pix_ready", pix_ready_s1, !m_busy);
    chk("bits_valid", bits_valid_s1, m_busy);
    chk("bits_v1", bits_v1, exp_bits());
    chk("bits_last", bits_last_s1, m_busy && m_nb == PIX_W - 1);
    chk("col_sel", col_sel_s1, 32'(1) << m_col);
    chk("row_ptr", row_ptr_s1, m_rp);
    chk("line_done", line_done_s1, m_ld);
  end

  int cyc = 0;
  logic [ROWS-1:0] cap_b[1024];
  bit cap_l[1024];
  int cap_n = 0, acc_n = 0, ld_n = 0;
  int acc_t[256];
  always @(posedge phi1) cyc++;
  always @(negedge phi1)
    if (!reset_s1) begin
      if (bits_valid_s1 && bits_ready_s1) begin
        cap_b[cap_n % 1024] = bits_v1;
        cap_l[cap_n % 1024] = bits_last_s1;
        cap_n++;
      end
      if (pix_valid_s1 && pix_ready_s1) begin
        acc_t[acc_n % 256] = cyc;
        acc_n++;
      end
      if (line_done_s1) ld_n++;
    end

  function automatic logic [7:0] row_word(input int base, input int k);
    logic [7:0] w;
    for (int i = 0; i < 8; i++) w[i] = cap_b[(base + i) % 1024][k];
    return w;
  endfunction

  task automatic tick();
    @(posedge phi1);
    #1;
  endtask

  task automatic put(input logic [7:0] p);
    int n = 0;
    pix_valid_s1 = 1;
    pixel_s1 = p;
    while (!pix_ready_s1 && n < 50) begin tick(); n++; end
    if (n == 50) to_fail("put");
    tick();
    pix_valid_s1 = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (!pix_ready_s1 && n < 100) begin tick(); n++; end
    if (n == 100) to_fail("drain");
  endtask

  task automatic send(input logic [7:0] p);
    put(p);
    drain();
  endtask

  task automatic do_reset();
    reset_s1 = 1;
    tick();
    tick();
    reset_s1 = 0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b, lb, n;
    logic [7:0] lm;
    do_reset();
    chk("rst_pix_ready", pix_ready_s1, 1);
    chk("rst_col_sel", col_sel_s1, 9'h001);
    // 1: single pixel A5 streamed on the newest row, LSB first
    b = cap_n;
    send(8'hA5);
    chk("t1_count", cap_n - b, 8);
    chk("t1_row2", row_word(b, 2), 8'hA5);
    chk("t1_row1", row_word(b, 1), 8'h00);
    chk("t1_row0", row_word(b, 0), 8'h00);
    for (int i = 0; i < 8; i++) lm[i] = cap_l[(b + i) % 1024];
    chk("t1_last", lm, 8'h80);
    // 2: a full line wraps col and advances row_ptr with one line_done
    do_reset();
    lb = ld_n;
    for (int i = 0; i < 8; i++) send(8'(i * 3 + 1));
    chk("t2_col_sel8", col_sel_s1, 9'h100);
    chk("t2_rp_before", row_ptr_s1, 0);
    send(8'h77);
    tick();
    tick();
    chk("t2_line_done", ld_n - lb, 1);
    chk("t2_rp_after", row_ptr_s1, 1);
    chk("t2_col_sel0", col_sel_s1, 9'h001);
    // 3: fourth line overwrites the oldest; readout in age order
    do_reset();
    for (int c = 0; c < COLS; c++) send(8'h11);
    for (int c = 0; c < COLS; c++) send(8'h22);
    for (int c = 0; c < COLS; c++) send(8'h33);
    for (int c = 0; c < 4; c++) send(8'h44);
    b = cap_n;
    send(8'h44);
    chk("t3_bit2", cap_b[(b + 2) % 1024], 3'b100);
    chk("t3_row0", row_word(b, 0), 8'h22);
    chk("t3_row1", row_word(b, 1), 8'h33);
    chk("t3_row2", row_word(b, 2), 8'h44);
    // 4: stall three cycles at bit 3
    do_reset();
    b = cap_n;
    put(8'hCA);
    tick(); tick(); tick();
    bits_ready_s1 = 0;
    for (int i = 0; i < 3; i++) begin
      chk("t4_stall_bits", bits_v1, 3'b100);
      chk("t4_stall_last", bits_last_s1, 0);
      chk("t4_stall_valid", bits_valid_s1, 1);
      tick();
    end
    bits_ready_s1 = 1;
    drain();
    chk("t4_count", cap_n - b, 8);
    chk("t4_row2", row_word(b, 2), 8'hCA);
    // 5: reset mid-shift abandons the column and clears memory
    do_reset();
    for (int c = 0; c < COLS; c++) send(8'hFF);
    put(8'h3C);
    for (int i = 0; i < 5; i++) tick();
    reset_s1 = 1;
    #1;
    chk("t5_valid", bits_valid_s1, 0);
    chk("t5_ready", pix_ready_s1, 1);
    chk("t5_bits", bits_v1, 0);
    chk("t5_last", bits_last_s1, 0);
    chk("t5_col_sel", col_sel_s1, 9'h001);
    chk("t5_rp", row_ptr_s1, 0);
    tick();
    reset_s1 = 0;
    tick();
    b = cap_n;
    send(8'h81);
    chk("t5_row0", row_word(b, 0), 8'h00);
    chk("t5_row1", row_word(b, 1), 8'h00);
    chk("t5_row2", row_word(b, 2), 8'h81);
    chk("t5_col_sel", col_sel_s1, 9'h002);
    // 6: pix_valid held high; second pixel waits for the first to finish
    do_reset();
    b = acc_n;
    lb = cap_n;
    pix_valid_s1 = 1;
    pixel_s1 = 8'h5A;
    n = 0;
    while (acc_n - b < 2 && n < 40) begin
      tick();
      if (acc_n - b >= 1) pixel_s1 = 8'hE7;
      n++;
    end
    pix_valid_s1 = 0;
    if (n == 40) to_fail("t6_accept");
    drain();
    chk("t6_gap", acc_t[(b + 1) % 256] - acc_t[b % 256], PIX_W + 1);
    chk("t6_p0", row_word(lb, 2), 8'h5A);
    chk("t6_p1", row_word(lb + 8, 2), 8'hE7);
    chk("t6_p1_oldrow", row_word(lb + 8, 0), 8'h00);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
